// File: rtl/amo_unit_mc_if.sv
// Core-side and memory-side request/response bundle of the atomic memory unit.
// The unit is the slave towards the core and drives the memory request fields.
interface amo_unit_mc_if #(
   parameter int N      = 2,
   parameter int XLEN   = 32,
   parameter int CBSIZE = 256
);
   logic [N-1:0]      core_id_i;
   logic              core_strobe_i;
   logic [XLEN-1:0]   core_addr_i;
   logic              core_rw_i;
   logic [CBSIZE-1:0] core_data_i;
   logic              core_is_amo_i;
   logic [4:0]        core_amo_type_i;
   logic              core_done_o;
   logic [CBSIZE-1:0] core_data_o;

   logic              M_DMEM_strobe_o;
   logic [XLEN-1:0]   M_DMEM_addr_o;
   logic              M_DMEM_rw_o;
   logic [CBSIZE-1:0] M_DMEM_data_o;
   logic              M_DMEM_done_i;
   logic [CBSIZE-1:0] M_DMEM_data_i;

   modport slave (
      input  core_id_i, core_strobe_i, core_addr_i,
      input  core_rw_i, core_data_i, core_is_amo_i,
      input  core_amo_type_i,
      output core_done_o, core_data_o,
      output M_DMEM_strobe_o, M_DMEM_addr_o,
      output M_DMEM_rw_o, M_DMEM_data_o,
      input  M_DMEM_done_i, M_DMEM_data_i
   );

   modport master (
      output core_id_i, core_strobe_i, core_addr_i,
      output core_rw_i, core_data_i, core_is_amo_i,
      output core_amo_type_i,
      input  core_done_o, core_data_o,
      input  M_DMEM_strobe_o, M_DMEM_addr_o,
      input  M_DMEM_rw_o, M_DMEM_data_o,
      output M_DMEM_done_i, M_DMEM_data_i
   );
endinterface

// File: rtl/amo_unit_mc.sv
// Multi-core RISC-V A-extension atomic unit: read-modify-write AMOs and
// per-core LR/SC reservations with granule match and expiry timer.
module amo_unit_mc #(
   parameter int N          = 2,
   parameter int XLEN       = 32,
   parameter int CBSIZE     = 256,
   parameter int GRAN_LOG2  = 5,
   parameter int LR_TIMEOUT = 1024
) (
   input logic           clk_i,
   input logic           rst_ni,
   amo_unit_mc_if.slave  bus
);
   localparam int LW     = CBSIZE / 32;
   localparam int OFFW   = $clog2(CBSIZE / 8);
   localparam int LANEW  = (OFFW > 2) ? OFFW - 2 : 1;
   localparam int IW     = $clog2(CBSIZE);
   localparam int GW     = XLEN - GRAN_LOG2;
   localparam int TW     = (LR_TIMEOUT > 1) ? $clog2(LR_TIMEOUT + 1) : 1;
   localparam bit TMR_ON = (LR_TIMEOUT != 0);

   typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

   state_t            state;
   logic [CBSIZE-1:0] cap;
   logic              strb_q;
   logic              rw_q;
   logic              done_q;
   logic              scf_q;

   logic [N-1:0]      valid;
   logic [GW-1:0]     resv [N];
   logic [TW-1:0]     tmr  [N];

   logic [LANEW-1:0]  w;
   logic [IW-1:0]     lo;
   logic [31:0]       rs1;
   logic [31:0]       rs2;
   logic [31:0]       alu;
   logic              lt;
   logic [4:0]        op;
   logic              is_lr;
   logic              is_sc;
   logic              amo_req;
   logic [GW-1:0]     gran;
   logic [N-1:0]      match;
   logic [N-1:0]      expire;
   logic              sc_ok;
   logic              wr_clr;
   logic              fin;
   logic [CBSIZE-1:0] wline;
   logic [CBSIZE-1:0] rline;

   if (LW > 1) begin : g_lane
      assign w = bus.core_addr_i[2 +: LANEW];
   end else begin : g_lane1
      assign w = '0;
   end

   // Lane 0 sits at the MSB end of the line.
   assign lo  = IW'(32 * (LW - 1 - int'(w)));
   assign rs1 = cap[lo +: 32];
   assign rs2 = bus.core_data_i[lo +: 32];

   assign op      = bus.core_amo_type_i;
   assign is_lr   = (op == 5'b00010);
   assign is_sc   = (op == 5'b00011);
   assign amo_req = bus.core_strobe_i & bus.core_is_amo_i;
   assign gran    = bus.core_addr_i[XLEN-1:GRAN_LOG2];
   assign fin     = (state == FIN);

   always_comb begin
      lt  = $signed({~op[3] & rs1[31], rs1})
          < $signed({~op[3] & rs2[31], rs2});
      alu = rs2;
      unique case (op)
         5'b00000: alu = rs1 + rs2;
         5'b00100: alu = rs1 ^ rs2;
         5'b01000: alu = rs1 | rs2;
         5'b01100: alu = rs1 & rs2;
         5'b10000: alu = lt ? rs1 : rs2;
         5'b10100: alu = lt ? rs2 : rs1;
         5'b11000: alu = lt ? rs1 : rs2;
         5'b11100: alu = lt ? rs2 : rs1;
         default:  alu = rs2;
      endcase
   end

   always_comb begin
      wline = cap;
      wline[lo +: 32] = alu;
   end

   always_comb begin
      rline = '0;
      rline[lo +: 32] = is_sc ? {31'b0, scf_q} : rs1;
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         match[i]  = (resv[i] == gran);
         expire[i] = TMR_ON && valid[i] && (tmr[i] == '0);
      end
   end

   // An expiring reservation cannot satisfy an SC in the same cycle.
   assign sc_ok = |(bus.core_id_i & valid & match & ~expire);

   assign wr_clr = (bus.core_strobe_i & ~bus.core_is_amo_i
                    & bus.core_rw_i & bus.M_DMEM_done_i)
                 | ((state == WR) & bus.M_DMEM_done_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= IDLE;
         cap    <= '0;
         strb_q <= 1'b0;
         rw_q   <= 1'b0;
         done_q <= 1'b0;
         scf_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (amo_req) begin
                  if (is_sc && !sc_ok) begin
                     state  <= FIN;
                     done_q <= 1'b1;
                     scf_q  <= 1'b1;
                  end else begin
                     state  <= RD;
                     strb_q <= 1'b1;
                     rw_q   <= 1'b0;
                     scf_q  <= 1'b0;
                  end
               end
            end
            RD: begin
               if (bus.M_DMEM_done_i) begin
                  cap <= bus.M_DMEM_data_i;
                  if (is_lr) begin
                     state  <= FIN;
                     strb_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     state <= WR;
                     rw_q  <= 1'b1;
                  end
               end
            end
            WR: begin
               if (bus.M_DMEM_done_i) begin
                  state  <= FIN;
                  strb_q <= 1'b0;
                  rw_q   <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            FIN: state <= IDLE;
         endcase
      end
   end

   // Later assignments take priority: LR set over write/SC clears over expiry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid <= '0;
         for (int i = 0; i < N; i++) begin
            resv[i] <= '0;
            tmr[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (valid[i] && TMR_ON) begin
               if (tmr[i] == '0) valid[i] <= 1'b0;
               else              tmr[i]   <= tmr[i] - TW'(1);
            end
            if (wr_clr && match[i])
               valid[i] <= 1'b0;
            if (fin && is_sc && bus.core_id_i[i])
               valid[i] <= 1'b0;
            if (fin && is_lr && bus.core_id_i[i]) begin
               valid[i] <= 1'b1;
               resv[i]  <= gran;
               tmr[i]   <= TW'(LR_TIMEOUT);
            end
         end
      end
   end

   always_comb begin
      bus.M_DMEM_addr_o = bus.core_addr_i;
      if (bus.core_is_amo_i) begin
         bus.M_DMEM_strobe_o = strb_q;
         bus.M_DMEM_rw_o     = rw_q;
         bus.M_DMEM_data_o   = wline;
         bus.core_done_o     = done_q;
         bus.core_data_o     = rline;
      end else begin
         bus.M_DMEM_strobe_o = bus.core_strobe_i;
         bus.M_DMEM_rw_o     = bus.core_rw_i;
         bus.M_DMEM_data_o   = bus.core_data_i;
         bus.core_done_o     = bus.M_DMEM_done_i;
         bus.core_data_o     = bus.M_DMEM_data_i;
      end
   end
endmodule

// File: doc/amo_unit_mc.md
# amo_unit_mc

Parametrised multi-core atomic memory unit placed between the core-side data-memory port and the D-cache/memory port. It executes RISC-V A-extension AMOs as read-modify-write sequences and tracks per-core LR/SC reservations, with a configurable granule and an expiry timer. It supports any core count and selects the 32-bit AMO lane inside the cache line from the address. Non-atomic traffic passes straight through.

## Interface
- N, 2, number of cores (≥1); core_id_i is one-hot over N
- XLEN, 32, address width
- CBSIZE, 256, cache-line width in bits; multiple of 32
- GRAN_LOG2, 5, log2 of the reservation granule in bytes (2..log2(CBSIZE/8))
- LR_TIMEOUT, 1024, reservation lifetime in cycles; 0 = never expires
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- core_id_i  in  N  requesting core, one-hot
- core_strobe_i  in  1  request valid; held with all request fields until core_done_o
- core_addr_i  in  XLEN  byte address
- core_rw_i  in  1  1 = write
- core_data_i  in  CBSIZE  write data; AMO operand in selected lane
- core_is_amo_i  in  1  request is atomic
- core_amo_type_i  in  5  funct5 (ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100)
- core_done_o  out  1  request complete, one cycle
- core_data_o  out  CBSIZE  read data
- M_DMEM_strobe_o / M_DMEM_addr_o / M_DMEM_rw_o / M_DMEM_data_o  out  1/XLEN/1/CBSIZE  memory request
- M_DMEM_done_i / M_DMEM_data_i  in  1/CBSIZE  memory response

## Operation
- Lane select: w = core_addr_i[log2(CBSIZE/8)-1:2]. Lane w = bits [CBSIZE-1-32w -: 32], so lane 0 is the MSBs. rs1 = memory lane w; rs2 = core_data_i lane w.
- Non-AMO (core_is_amo_i=0): all M_DMEM_* and core_* signals are combinational pass-throughs; the FSM stays in IDLE.
- FSM states: IDLE, RD, WR, FIN.
  - IDLE→FIN: AMO strobe that is an SC, when the SC fails.
  - IDLE→RD: any other AMO strobe, including a successful SC.
  - RD→FIN: M_DMEM_done_i with LR.
  - RD→WR: M_DMEM_done_i otherwise. The memory line is captured in this transition cycle.
  - WR→FIN: M_DMEM_done_i.
  - FIN→IDLE: always.
- AMO memory side:
  - M_DMEM_strobe_o = 1 throughout RD and WR; M_DMEM_rw_o = 1 only in WR.
  - M_DMEM_addr_o = core_addr_i.
  - Write data = captured line with lane w replaced by the ALU result.
- ALU: bit op[3]=1 selects an unsigned compare, via a 33-bit sign/zero-extended less-than. SC and SWAP write rs2; unknown op writes rs2.
- core_done_o = 1 only in FIN for AMOs.
- core_data_o for AMOs: lane w = rs1, or for SC {31'b0, fail}; all other bits 0.
- Reservation state per core i: valid[i], granule address resv[i] = addr[XLEN-1:GRAN_LOG2], and a down-counter tmr[i].
  - LR completion (FIN): set valid, store the granule, load tmr = LR_TIMEOUT.
  - SC success: requires valid & granule match for the requesting core, evaluated in IDLE.
  - Any SC completion clears the requester's reservation, whether it succeeded or failed.
  - Any completed write clears every core's reservation whose granule matches (plain store on done, or AMO/SC write phase on M_DMEM_done_i in WR).
  - tmr decrements each cycle while valid; reaching 0 clears valid. With LR_TIMEOUT=0 the counter is unused.
- Simultaneous events:
  - Expiry in the same cycle as an SC evaluation → SC fails.
  - An LR by core A does not disturb core B's reservation on the same granule.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE; valid=0, resv=0, tmr=0; capture register 0.
  - Outputs become pass-throughs of the core/memory inputs. With core_strobe_i=0, M_DMEM_strobe_o=0 and core_done_o=M_DMEM_done_i.
- Reset mid-AMO: strobe drops immediately and the transaction is abandoned; the memory side must tolerate this.
- Latency, with memory latency L cycles per access:
  - AMO: 2L+1 cycles from strobe to done.
  - LR: L+1 cycles.
  - Failed SC: done in the cycle after the strobe, with no memory access.
- core_done_o is a 1-cycle pulse. The core may issue its next request in the cycle after done.

## Test plan
- AMOADD.W, addr 0x104 (lane 1), mem lane=5, rs2=7 → RD then WR; written lane 1=12, other lanes unchanged; core_data_o lane1=5; done after 2L+1 cycles.
- AMOMIN vs AMOMINU, mem=0xFFFFFFFF, rs2=1 → MIN writes 0xFFFFFFFF; MINU writes 1.
- Core 0 LR @0x200 then SC @0x204 (same 32 B granule) → SC writes, returns 0. A second SC → returns 1 in 1 cycle, no M_DMEM strobe.
- Core 0 LR @0x200; core 1 plain store @0x21C; core 0 SC → fail (1). Repeat with the store @0x220 → success.
- LR_TIMEOUT=8: LR, idle 8 cycles, SC → fail. Idle 7 cycles, SC → success.
- rst_ni low during WR → strobe drops that cycle, all valid=0; SC after release → fail.
